player_ctrl: RTL and testbench
==============================

// Module: player_ctrl
// PURPOSE
//  Parametrised player controller for the TinyTapeStation game core. Moves the player on a
//  GRID_W x GRID_H tile grid, spawns a timed sword in the facing direction, and tracks
//  health, damage and death/restart. Runs once per game step (frame_tick). Drives
//  player/sword entity words to the collision and sprite logic.
// PARAMETERS
//  GRID_W        16  grid width in tiles (<= 2**X_BITS)
//  GRID_H        12  grid height in tiles (<= 2**Y_BITS)
//  X_BITS        4   x coordinate width
//  Y_BITS        4   y coordinate width
//  MAX_HEALTH    3   health at reset/restart
//  HP_BITS       2   health width
//  MOVE_COOLDOWN 2   frame ticks after a move before the next move is accepted
//  ATTACK_TICKS  3   frame ticks the sword stays visible
//  INVULN_TICKS  8   frame ticks of hit immunity (PLAYER_INVULN_EN only)
//  START_X/START_Y 7/5 spawn tile
// PORTS
//  clk          in   1   system clock
//  reset        in   1   synchronous, active-high reset
//  frame_tick   in   1   one-cycle game-step strobe
//  A, B         in   1   attack buttons
//  up,down,left,right in 1 direction buttons
//  start        in   1   restart request (honoured only in DEAD)
//  select       in   1   unused
//  hit          in   1   one-cycle damage pulse from collision logic
//  player       out  6+X_BITS+Y_BITS  {id[3:0]=0010, orient[1:0], x, y}
//  sword        out  6+X_BITS+Y_BITS  {id, orient, x, y}; hidden = {1111, 01, 0, 0}
//  player_health out HP_BITS  current health
//  dead         out  1   high in DEAD
// BEHAVIOUR
//  Reset: state IDLE, player={0010,01,START_X,START_Y}, sword hidden, health=MAX_HEALTH,
//   dead=0, cooldown, attack and invuln counters=0. All outputs registered.
//  Orient: 00 up, 01 right, 10 down, 11 left. dir_valid = exactly one of up/down/left/right.
//  Actions are evaluated only on cycles with frame_tick=1. Results visible the next cycle.
//  IDLE, on tick, priority: (A|B) -> ATTACK; else dir_valid -> move.
//   Move: orient <= dir (all four directions). Step one tile unless already at the edge
//   (x=0/GRID_W-1, y=0/GRID_H-1). At the edge only orient changes and no cooldown starts.
//   After a real step, cooldown <= MOVE_COOLDOWN. Moves are ignored while cooldown != 0.
//   Cooldown decrements on each tick, to 0.
//  ATTACK entry: if dir_valid, orient <= dir, else the current orient is kept. Target tile =
//   neighbour in orient. If the target is off-grid, stay IDLE and the sword stays hidden.
//   Otherwise sword <= {0001, orient, target}, atk_cnt <= ATTACK_TICKS-1.
//   In ATTACK: player frozen; each tick, if atk_cnt=0 then hide sword, go IDLE; else decrement.
//   The cooldown counter continues to decrement in ATTACK.
//  hit (any cycle, independent of tick): health decrements, saturating at 0.
//   When health becomes 0, next cycle: DEAD, sword hidden, dead=1.
//   Same-cycle hit and tick: the hit applies. The tick action is suppressed if the
//   hit drives health to 0.
//  DEAD: all inputs except start/reset ignored; position frozen. tick & start -> restart:
//   identical to reset values (state IDLE, dead=0).
//  reset mid-attack/mid-cooldown: everything returns to reset values the next cycle.
//  Width rules: x/y arithmetic stays within X_BITS/Y_BITS; no wrap is possible because of
//   the edge checks.
// CONFIGURATION
//  PLAYER_INVULN_EN defined: an accepted hit loads invuln <= INVULN_TICKS. Hits are
//   ignored while invuln != 0. invuln decrements on each tick.
//  PLAYER_INVULN_EN undefined: every hit pulse decrements health, including hits on
//   back-to-back cycles. The invuln counter is not built.
// TESTING
//  reset, tick+right x3 with MOVE_COOLDOWN=0 -> player x 7->10, orient 01, y=5.
//  at x=15, tick+right -> x stays 15, orient 01. tick+up at y=0 -> y stays 0, orient 00.
//  tick+A facing right at (7,5) -> sword={0001,01,8,5} for 3 ticks, then hidden.
//   Player does not move during this time.
//  3 hit pulses with the macro off -> health 3,2,1,0, then dead=1.
//   tick+right while dead -> no move. tick+start -> reset values.
//  PLAYER_INVULN_EN: hit, hit on the next cycle -> health 2 only. After 8 ticks a hit -> 1.
//  hit+tick+left on the same cycle with health=1 -> DEAD, x unchanged.

Source files
------------

// File: rtl/player_ctrl.sv
// player_ctrl: grid movement, timed sword and health/death for one player.
// Define PLAYER_INVULN_EN to add a hit-immunity window after each hit.
module player_ctrl #(
  parameter int GRID_W        = 16,
  parameter int GRID_H        = 12,
  parameter int X_BITS        = 4,
  parameter int Y_BITS        = 4,
  parameter int MAX_HEALTH    = 3,
  parameter int HP_BITS       = 2,
  parameter int MOVE_COOLDOWN = 2,
  parameter int ATTACK_TICKS  = 3,
  parameter int INVULN_TICKS  = 8,
  parameter int START_X       = 7,
  parameter int START_Y       = 5
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     frame_tick,
  input  logic                     A,
  input  logic                     B,
  input  logic                     up,
  input  logic                     down,
  input  logic                     left,
  input  logic                     right,
  input  logic                     start,
  input  logic                     select,
  input  logic                     hit,
  output logic [5+X_BITS+Y_BITS:0] player,
  output logic [5+X_BITS+Y_BITS:0] sword,
  output logic [HP_BITS-1:0]       player_health,
  output logic                     dead
);

  localparam int EW   = 6 + X_BITS + Y_BITS;
  localparam int CD_W = $clog2(MOVE_COOLDOWN + 2);
  localparam int AT_W = $clog2(ATTACK_TICKS + 1);
  localparam int NB_W = 1 + X_BITS + Y_BITS;

  localparam logic [3:0] ID_PLAYER = 4'b0010;
  localparam logic [3:0] ID_SWORD  = 4'b0001;
  localparam logic [EW-1:0] HIDDEN =
    {4'b1111, 2'b01, {(X_BITS + Y_BITS){1'b0}}};

  typedef enum logic [1:0] {
    S_IDLE,
    S_ATTACK,
    S_DEAD
  } state_t;

  state_t             state;
  logic [1:0]         orient;
  logic [X_BITS-1:0]  px;
  logic [Y_BITS-1:0]  py;
  logic [EW-1:0]      sword_q;
  logic [HP_BITS-1:0] health;
  logic               dead_q;
  logic [CD_W-1:0]    cooldown;
  logic [AT_W-1:0]    atk_cnt;

  logic               dir_valid;
  logic [1:0]         dir_o;
  logic               nb_ok;
  logic [X_BITS-1:0]  nb_x;
  logic [Y_BITS-1:0]  nb_y;
  logic               hit_ok;
  logic               kill;
  logic               restart;
  logic               unused_ok;

  // {in_grid, x, y} of the tile adjacent to (x, y) in direction o
  function automatic logic [NB_W-1:0] neighbour(
    input logic [1:0]        o,
    input logic [X_BITS-1:0] x,
    input logic [Y_BITS-1:0] y
  );
    logic [NB_W-1:0] r;
    r = {1'b0, x, y};
    case (o)
      2'b00:
        if (y != '0)
          r = {1'b1, x, y - Y_BITS'(1)};
      2'b01:
        if (x != X_BITS'(GRID_W - 1))
          r = {1'b1, x + X_BITS'(1), y};
      2'b10:
        if (y != Y_BITS'(GRID_H - 1))
          r = {1'b1, x, y + Y_BITS'(1)};
      2'b11:
        if (x != '0)
          r = {1'b1, x - X_BITS'(1), y};
    endcase
    return r;
  endfunction

  // dir_o falls back to the current facing, so it is also the attack facing
  always_comb begin
    dir_valid = $onehot({up, down, left, right});
    dir_o     = orient;
    if (dir_valid) begin
      unique case (1'b1)
        up:      dir_o = 2'b00;
        right:   dir_o = 2'b01;
        down:    dir_o = 2'b10;
        left:    dir_o = 2'b11;
        default: dir_o = orient;
      endcase
    end
    {nb_ok, nb_x, nb_y} = neighbour(dir_o, px, py);
  end

  assign restart = (state == S_DEAD) && frame_tick && start;

`ifdef PLAYER_INVULN_EN
  localparam int IV_W = $clog2(INVULN_TICKS + 2);

  logic [IV_W-1:0] invuln;

  assign hit_ok = hit && (invuln == '0);

  always_ff @(posedge clk) begin
    if (reset || restart) begin
      invuln <= '0;
    end else if (state != S_DEAD) begin
      if (hit_ok)
        invuln <= IV_W'(INVULN_TICKS);
      else if (frame_tick && invuln != '0)
        invuln <= invuln - IV_W'(1);
    end
  end
`else
  assign hit_ok = hit;
`endif

  assign kill      = hit_ok && (health == HP_BITS'(1));
  assign unused_ok = select ^ (INVULN_TICKS == 0);

  always_ff @(posedge clk) begin
    if (reset || restart) begin
      state    <= S_IDLE;
      orient   <= 2'b01;
      px       <= X_BITS'(START_X);
      py       <= Y_BITS'(START_Y);
      sword_q  <= HIDDEN;
      health   <= HP_BITS'(MAX_HEALTH);
      dead_q   <= 1'b0;
      cooldown <= '0;
      atk_cnt  <= '0;
    end else if (state != S_DEAD) begin
      if (hit_ok && health != '0)
        health <= health - HP_BITS'(1);
      if (kill) begin
        state   <= S_DEAD;
        dead_q  <= 1'b1;
        sword_q <= HIDDEN;
      end else if (frame_tick) begin
        if (cooldown != '0)
          cooldown <= cooldown - CD_W'(1);
        if (state == S_ATTACK) begin
          if (atk_cnt == '0) begin
            sword_q <= HIDDEN;
            state   <= S_IDLE;
          end else begin
            atk_cnt <= atk_cnt - AT_W'(1);
          end
        end else if (A || B) begin
          orient <= dir_o;
          if (nb_ok) begin
            sword_q <= {ID_SWORD, dir_o, nb_x, nb_y};
            atk_cnt <= AT_W'(ATTACK_TICKS - 1);
            state   <= S_ATTACK;
          end
        end else if (dir_valid && cooldown == '0) begin
          orient <= dir_o;
          if (nb_ok) begin
            px       <= nb_x;
            py       <= nb_y;
            cooldown <= CD_W'(MOVE_COOLDOWN);
          end
        end
      end
    end
  end

  assign player        = {ID_PLAYER, orient, px, py};
  assign sword         = sword_q;
  assign player_health = health;
  assign dead          = dead_q;

endmodule

// File: tb/tb_player_ctrl.sv
// tb_player_ctrl: directed literals plus random stimulus against a
// tick-level behavioural model of the player controller.
module tb_player_ctrl;

  localparam int GW = 16;
  localparam int GH = 12;
  localparam int MH = 3;
  localparam int CD = 2;
  localparam int AT = 3;
  localparam int IV = 8;
  localparam int SX = 7;
  localparam int SY = 5;

  localparam logic [3:0] UP = 4'b1000;
  localparam logic [3:0] RT = 4'b0100;
  localparam logic [3:0] DN = 4'b0010;
  localparam logic [3:0] LT = 4'b0001;

  localparam logic [13:0] HID = 14'b1111_01_0000_0000;
  localparam logic [13:0] P0  = 14'b0010_01_0111_0101;

  logic clk = 1'b0;
  logic reset, frame_tick, A, B, up, down, left, right;
  logic start, select, hit;
  logic [13:0] player, sword;
  logic [1:0] player_health;
  logic dead;

  int checks = 0;
  int errors = 0;

  player_ctrl dut (
    .clk(clk), .reset(reset), .frame_tick(frame_tick),
    .A(A), .B(B), .up(up), .down(down), .left(left), .right(right),
    .start(start), .select(select), .hit(hit),
    .player(player), .sword(sword),
    .player_health(player_health), .dead(dead)
  );

  always #5 clk = ~clk;

  // model state: sword is visible while m_left > 0
  bit m_on = 0;
  bit m_dead;
  int m_x, m_y, m_o, m_hp, m_cd, m_iv, m_left;
  int s_x, s_y, s_o;
  int dxs[4] = '{0, 1, 0, -1};
  int dys[4] = '{-1, 0, 1, 0};

  task automatic m_reset();
    m_on = 1; m_dead = 0;
    m_x = SX; m_y = SY; m_o = 1;
    m_hp = MH; m_cd = 0; m_iv = 0; m_left = 0;
  endtask

  task automatic model_step();
    bit acc;
    int nd, cd_old, dir, nx, ny;
    if (reset || (m_dead && frame_tick && start)) begin
      m_reset();
      return;
    end
    if (!m_on || m_dead) return;
    acc = hit;
`ifdef PLAYER_INVULN_EN
    acc = hit && (m_iv == 0);
    if (acc) m_iv = IV;
    else if (frame_tick && m_iv > 0) m_iv--;
`endif
    if (acc && m_hp > 0) m_hp--;
    if (m_hp == 0) begin
      m_dead = 1; m_left = 0;
      return;
    end
    if (!frame_tick) return;
    cd_old = m_cd;
    if (m_cd > 0) m_cd--;
    if (m_left > 0) begin
      m_left--;
      return;
    end
    nd = int'(up) + int'(down) + int'(left) + int'(right);
    dir = up ? 0 : right ? 1 : down ? 2 : 3;
    if (A || B) begin
      if (nd == 1) m_o = dir;
      nx = m_x + dxs[m_o]; ny = m_y + dys[m_o];
      if (nx >= 0 && nx < GW && ny >= 0 && ny < GH) begin
        m_left = AT; s_x = nx; s_y = ny; s_o = m_o;
      end
    end else if (nd == 1 && cd_old == 0) begin
      m_o = dir;
      nx = m_x + dxs[m_o]; ny = m_y + dys[m_o];
      if (nx >= 0 && nx < GW && ny >= 0 && ny < GH) begin
        m_x = nx; m_y = ny; m_cd = CD;
      end
    end
  endtask

  initial forever begin
    @(posedge clk);
    model_step();
  end

  task automatic chk(input string nm, input logic [31:0] got,
                     input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got %h want %h at %0t", nm, got, want, $time);
    end
  endtask

  initial forever begin
    logic [13:0] ep, es;
    @(negedge clk);
    if (m_on) begin
      ep = {4'b0010, 2'(m_o), 4'(m_x), 4'(m_y)};
      es = (m_left > 0) ? {4'b0001, 2'(s_o), 4'(s_x), 4'(s_y)} : HID;
      chk("model_player", 32'(player), 32'(ep));
      chk("model_sword", 32'(sword), 32'(es));
      chk("model_health", 32'(player_health), 32'(m_hp));
      chk("model_dead", 32'(dead), 32'(m_dead));
    end
  end

  task automatic drive(input bit t, input bit a, input logic [3:0] d,
                       input bit st, input bit h);
    frame_tick = t; A = a; B = 1'b0;
    {up, right, down, left} = d;
    start = st; hit = h; reset = 1'b0; select = 1'b0;
    @(negedge clk);
  endtask

  task automatic rst_seq();
    reset = 1'b1;
    {frame_tick, A, B, up, down, left, right, start, hit} = '0;
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic idle_ticks(input int n);
    repeat (n) drive(1, 0, 4'b0, 0, 0);
  endtask

  task automatic lose_health_to_one();
    drive(0, 0, 4'b0, 0, 1);
`ifdef PLAYER_INVULN_EN
    idle_ticks(IV);
`endif
    drive(0, 0, 4'b0, 0, 1);
`ifdef PLAYER_INVULN_EN
    idle_ticks(IV);
`endif
  endtask

  initial begin
    {frame_tick, A, B, up, down, left, right, start, select, hit} = '0;
    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    chk("rst_player", 32'(player), 32'(P0));
    chk("rst_sword", 32'(sword), 32'(HID));
    chk("rst_health", 32'(player_health), 32'd3);
    chk("rst_dead", 32'(dead), 32'd0);

    repeat (3) begin
      drive(1, 0, RT, 0, 0);
      idle_ticks(CD);
    end
    chk("move_x10", 32'(player), 32'(14'b0010_01_1010_0101));
    drive(1, 0, RT, 0, 0);
    drive(1, 0, RT, 0, 0);
    chk("cooldown_block", 32'(player), 32'(14'b0010_01_1011_0101));
    idle_ticks(CD);
    repeat (6) begin
      drive(1, 0, RT, 0, 0);
      idle_ticks(CD);
    end
    chk("edge_right", 32'(player), 32'(14'b0010_01_1111_0101));
    repeat (7) begin
      drive(1, 0, UP, 0, 0);
      idle_ticks(CD);
    end
    chk("edge_up", 32'(player), 32'(14'b0010_00_1111_0000));
    drive(1, 1, 4'b0, 0, 0);
    chk("atk_offgrid", 32'(sword), 32'(HID));
    drive(1, 0, LT, 0, 0);
    chk("after_offgrid", 32'(player), 32'(14'b0010_11_1110_0000));

    rst_seq();
    drive(1, 1, 4'b0, 0, 0);
    chk("atk_sword", 32'(sword), 32'(14'b0001_01_1000_0101));
    repeat (2) begin
      drive(1, 0, RT, 0, 0);
      chk("atk_hold", 32'(sword), 32'(14'b0001_01_1000_0101));
      chk("atk_frozen", 32'(player), 32'(P0));
    end
    drive(1, 0, 4'b0, 0, 0);
    chk("atk_hide", 32'(sword), 32'(HID));
    drive(1, 1, DN, 0, 0);
    chk("atk_turn_sword", 32'(sword), 32'(14'b0001_10_0111_0110));
    chk("atk_turn_player", 32'(player), 32'(14'b0010_10_0111_0101));
    idle_ticks(AT + 1);

    rst_seq();
    drive(0, 0, 4'b0, 0, 1);
    chk("hit1", 32'(player_health), 32'd2);
    drive(0, 0, 4'b0, 0, 1);
`ifdef PLAYER_INVULN_EN
    chk("hit_immune", 32'(player_health), 32'd2);
    idle_ticks(IV);
    drive(0, 0, 4'b0, 0, 1);
    chk("hit_after_iv", 32'(player_health), 32'd1);
    idle_ticks(IV);
`else
    chk("hit2", 32'(player_health), 32'd1);
`endif
    drive(0, 0, 4'b0, 0, 1);
    chk("hit_zero", 32'(player_health), 32'd0);
    chk("hit_dead", 32'(dead), 32'd1);
    drive(1, 0, RT, 0, 0);
    chk("dead_frozen", 32'(player), 32'(P0));
    drive(1, 0, 4'b0, 1, 0);
    chk("restart_hp", 32'(player_health), 32'd3);
    chk("restart_dead", 32'(dead), 32'd0);
    chk("restart_player", 32'(player), 32'(P0));

    rst_seq();
    lose_health_to_one();
    drive(1, 0, LT, 0, 1);
    chk("kill_tick_dead", 32'(dead), 32'd1);
    chk("kill_tick_pos", 32'(player), 32'(P0));
    drive(1, 0, 4'b0, 1, 0);

    for (int i = 0; i < 4000; i++) begin
      reset = ($urandom_range(0, 299) == 0);
      frame_tick = 1'($urandom_range(0, 1));
      A = ($urandom_range(0, 7) == 0);
      B = ($urandom_range(0, 9) == 0);
      if ($urandom_range(0, 1) == 1)
        {up, right, down, left} = 4'(1 << $urandom_range(0, 3));
      else
        {up, right, down, left} = 4'($urandom_range(0, 15));
      start = ($urandom_range(0, 3) == 0);
      select = 1'($urandom_range(0, 1));
      hit = ($urandom_range(0, 19) == 0);
      @(negedge clk);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
